// File: rtl/ram_master_pkg.sv
// Shared types and sizing for the RAM bus master: FSM states, command record, bus widths.
// Pure declarations, no logic or latency.
// No flow control here; consumers apply it.
package ram_master_pkg;

  // Bus geometry of the shared single-port RAM.
  localparam int BYTE  = 8;
  localparam int NBITS = 8;
  localparam int WORDS = 256;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN
  } state_t;

  typedef struct packed {
    logic             write;
    logic [NBITS-1:0] addr;
    logic [NBITS-1:0] len;
  } cmd_t;

endpackage

// File: rtl/ram_bus.sv
// Signal bundle between a bus master and the single-port RAM.
// The RAM registers q one cycle after addr is presented.
// No flow control: the RAM accepts an access every cycle.
interface ram_bus;
  import ram_master_pkg::*;

  logic             we;
  logic [NBITS-1:0] addr;
  logic [BYTE-1:0]  data;
  logic [BYTE-1:0]  q;

  modport master (output we, output addr, output data, input q);
  modport slave  (input we, input addr, input data, output q);

endinterface

// File: rtl/ram_master_fifo.sv
// Small synchronous FIFO holding read bytes returned by the RAM.
// Head is visible the cycle after a push; push and pop may coincide.
// Pop on empty is ignored; push on full is dropped unless a pop frees the slot.
module ram_master_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ram_master.sv
// Burst bus master for the single-port RAM: write bursts from a byte stream, read bursts to a byte stream.
// Write beats hit the RAM the cycle they are accepted; read bytes appear 2 cycles after issue.
// Reads are credit-limited to the FIFO depth so rd_ready may stall indefinitely. Optional RAM_MASTER_BOUNDS_EN rejects out-of-range commands with err.
module ram_master
  import ram_master_pkg::*;
#(
  parameter int RD_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [NBITS-1:0] cmd_addr,
  input  logic [NBITS-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [BYTE-1:0]  wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [BYTE-1:0]  rd_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  ram_bus.master           bus
);

  localparam int CW = $clog2(RD_DEPTH + 1);

  state_t           state;
  cmd_t             cmd_in;
  logic [NBITS-1:0] cur_addr;
  logic [NBITS-1:0] beats_left;
  logic [NBITS-1:0] addr_hold;
  logic [BYTE-1:0]  data_hold;
  logic             in_flight;
  logic [CW-1:0]    fifo_count;
  logic             pop;
  logic             issue;
  logic             wr_beat;
  logic             bounds_bad;
  logic             done_q;
  logic             err_q;

  assign cmd_in.write = cmd_write;
  assign cmd_in.addr  = cmd_addr;
  assign cmd_in.len   = cmd_len;

`ifdef RAM_MASTER_BOUNDS_EN
  // Widened so that addr + len + 1 cannot wrap before the comparison.
  assign bounds_bad = ({2'b00, cmd_in.addr} + {2'b00, cmd_in.len} + (NBITS + 2)'(1))
                      > (NBITS + 2)'(WORDS);
`else
  assign bounds_bad = 1'b0;
`endif

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign wr_ready  = (state == WRITE);
  assign done      = done_q;
  assign err       = err_q;

  assign rd_valid  = (fifo_count != '0);
  assign pop       = rd_valid && rd_ready;
  assign wr_beat   = (state == WRITE) && wr_valid;

  // A pop in this cycle frees a slot before the byte issued now lands,
  // which is what lets a depth-2 FIFO sustain one byte per cycle.
  assign issue = (state == READ) &&
                 ((int'(fifo_count) + int'(in_flight) - int'(pop)) < RD_DEPTH);

  // Writes present the incoming byte combinationally so the RAM captures it at this edge.
  assign bus.we   = wr_beat;
  assign bus.addr = ((state == WRITE) || (state == READ)) ? cur_addr : addr_hold;
  assign bus.data = wr_beat ? wr_data : data_hold;

  // Burst sequencing, in-flight tracking and the done/err pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_addr   <= '0;
      beats_left <= '0;
      addr_hold  <= '0;
      data_hold  <= '0;
      in_flight  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      addr_hold <= bus.addr;
      data_hold <= bus.data;
      in_flight <= issue;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (bounds_bad) begin
              err_q <= 1'b1;
            end else begin
              state      <= cmd_in.write ? WRITE : READ;
              cur_addr   <= cmd_in.addr;
              beats_left <= cmd_in.len;
            end
          end
        end
        WRITE: begin
          if (wr_valid) begin
            cur_addr   <= cur_addr + 1'b1;
            beats_left <= beats_left - 1'b1;
            if (beats_left == '0) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            cur_addr   <= cur_addr + 1'b1;
            beats_left <= beats_left - 1'b1;
            if (beats_left == '0) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Finish in the cycle the last byte leaves so done follows it directly.
          if (!in_flight && ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop))) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The RAM's registered read data is pushed the cycle after each issue.
  ram_master_fifo #(
    .DEPTH (RD_DEPTH),
    .WIDTH (BYTE)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_flight),
    .push_data (bus.q),
    .pop       (pop),
    .head      (rd_data),
    .count     (fifo_count)
  );

endmodule
